// File: rtl/cdb_pkg.sv
// Shared CDB definitions: word layout, unit codes and the result entry type.
// The reservation stations import this package as well.
package cdb_pkg;

   localparam int CDB_W         = 22;
   localparam int CDB_DATA_LSB  = 0;
   localparam int CDB_DATA_MSB  = 15;
   localparam int CDB_DEST_LSB  = 16;
   localparam int CDB_DEST_MSB  = 18;
   localparam int CDB_LABEL_BIT = 19;
   localparam int CDB_UNIT_BIT  = 20;
   localparam int CDB_VALID_BIT = 21;

   localparam logic UNIT_ADD = 1'b0;
   localparam logic UNIT_MUL = 1'b1;

   typedef struct packed {
      logic        label;
      logic [2:0]  dest;
      logic [15:0] data;
   } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO with explicit occupancy count, push, pop and flush.
// A full FIFO refuses pushes even in a cycle where it also pops.
module cdb_src_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ready,
   output logic                     not_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign ready     = (count_q < CW'(DEPTH));
   assign not_empty = (count_q != '0);
   assign head      = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign do_push   = push && ready && !flush;
   assign do_pop    = pop && not_empty && !flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries only data; occupancy lives in the control flops above.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises adder and multiplier results onto the single registered CDB,
// round-robin between the two source FIFOs, at most one broadcast per cycle.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_AW     = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          add_valid,
   input  logic [DATA_W-1:0]             add_data,
   input  logic [REG_AW-1:0]             add_dest,
   input  logic                          add_label,
   output logic                          add_ready,
   input  logic                          mul_valid,
   input  logic [DATA_W-1:0]             mul_data,
   input  logic [REG_AW-1:0]             mul_dest,
   input  logic                          mul_label,
   output logic                          mul_ready,
   output logic [CDB_W-1:0]              cdb,
   output logic [$clog2(FIFO_DEPTH):0]   add_count,
   output logic [$clog2(FIFO_DEPTH):0]   mul_count
);
   localparam int ENTRY_W = 1 + REG_AW + DATA_W;

   logic [ENTRY_W-1:0] add_head, mul_head;
   logic               add_ne, mul_ne;
   logic               add_pop, mul_pop;
   logic               rr_last_q, rr_last_d;
   logic [CDB_W-1:0]   cdb_q, cdb_d;

   cdb_src_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_add_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (add_valid),
      .push_data ({add_label, add_dest, add_data}),
      .pop       (add_pop),
      .head      (add_head),
      .count     (add_count),
      .ready     (add_ready),
      .not_empty (add_ne)
   );

   cdb_src_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_mul_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (mul_valid),
      .push_data ({mul_label, mul_dest, mul_data}),
      .pop       (mul_pop),
      .head      (mul_head),
      .count     (mul_count),
      .ready     (mul_ready),
      .not_empty (mul_ne)
   );

   // Grant looks only at heads already stored, so a fresh push waits one edge.
   always_comb begin
      add_pop   = 1'b0;
      mul_pop   = 1'b0;
      rr_last_d = rr_last_q;
      cdb_d     = '0;
      if (flush) begin
         rr_last_d = UNIT_MUL;
      end else if (add_ne && (!mul_ne || rr_last_q == UNIT_MUL)) begin
         add_pop   = 1'b1;
         rr_last_d = UNIT_ADD;
         cdb_d     = {1'b1, UNIT_ADD, add_head};
      end else if (mul_ne) begin
         mul_pop   = 1'b1;
         rr_last_d = UNIT_MUL;
         cdb_d     = {1'b1, UNIT_MUL, mul_head};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_last_q <= UNIT_MUL;
         cdb_q     <= '0;
      end else begin
         rr_last_q <= rr_last_d;
         cdb_q     <= cdb_d;
      end
   end

   assign cdb = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, contention/reset/flush
// sequences and random traffic, all checked against a queue-based model.
module tb_cdb_arbiter;
   localparam int DEPTH = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        add_valid, mul_valid;
   logic [15:0] add_data, mul_data;
   logic [2:0]  add_dest, mul_dest;
   logic        add_label, mul_label;
   logic        add_ready, mul_ready;
   logic [21:0] cdb;
   logic [1:0]  add_count, mul_count;

   cdb_arbiter #(.DATA_W(16), .REG_AW(3), .FIFO_DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .add_valid (add_valid),
      .add_data  (add_data),
      .add_dest  (add_dest),
      .add_label (add_label),
      .add_ready (add_ready),
      .mul_valid (mul_valid),
      .mul_data  (mul_data),
      .mul_dest  (mul_dest),
      .mul_label (mul_label),
      .mul_ready (mul_ready),
      .cdb       (cdb),
      .add_count (add_count),
      .mul_count (mul_count)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model: one queue of {label,dest,data} per source.
   logic [19:0] add_q[$];
   logic [19:0] mul_q[$];
   logic        m_rr;
   logic [21:0] exp_cdb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      add_q.delete();
      mul_q.delete();
      m_rr    = 1'b1;
      exp_cdb = '0;
   endtask

   task automatic model_edge();
      int asz = add_q.size();
      int msz = mul_q.size();
      logic [19:0] e;
      if (flush) begin
         model_reset();
         return;
      end
      if (asz > 0 && (msz == 0 || m_rr == 1'b1)) begin
         e = add_q.pop_front();
         exp_cdb = {2'b10, e};
         m_rr = 1'b0;
      end else if (msz > 0) begin
         e = mul_q.pop_front();
         exp_cdb = {2'b11, e};
         m_rr = 1'b1;
      end else begin
         exp_cdb = '0;
      end
      if (add_valid && asz < DEPTH) add_q.push_back({add_label, add_dest, add_data});
      if (mul_valid && msz < DEPTH) mul_q.push_back({mul_label, mul_dest, mul_data});
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".cdb"},       32'(cdb),       32'(exp_cdb));
      chk({tag, ".add_count"}, 32'(add_count), 32'(add_q.size()));
      chk({tag, ".mul_count"}, 32'(mul_count), 32'(mul_q.size()));
      chk({tag, ".add_ready"}, 32'(add_ready), 32'(add_q.size() < DEPTH));
      chk({tag, ".mul_ready"}, 32'(mul_ready), 32'(mul_q.size() < DEPTH));
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clock);
      #1;
      check_model(tag);
   endtask

   task automatic idle();
      flush = 1'b0;
      add_valid = 1'b0;
      mul_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   typedef struct {
      logic        fl;
      logic        av;
      logic [15:0] ad;
      logic [2:0]  ade;
      logic        al;
      logic        mv;
      logic [15:0] md;
      logic [2:0]  mde;
      logic        ml;
      logic [21:0] e_cdb;
      logic [1:0]  e_ac;
      logic [1:0]  e_mc;
   } vec_t;

   vec_t vt[15];
   logic saw_add_stall, saw_mul_stall;
   int   a_seq, m_seq;

   initial begin
      //        fl  av  ad        ade   al  mv  md        mde   ml  cdb           ac  mc
      vt[0]  = '{0, 1, 16'h1234, 3'd5, 1, 0, 16'h0000, 3'd0, 0, 22'h000000, 1, 0};
      vt[1]  = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h2D1234, 0, 0};
      vt[2]  = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h000000, 0, 0};
      vt[3]  = '{1, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h000000, 0, 0};
      vt[4]  = '{0, 1, 16'h0001, 3'd1, 0, 1, 16'h0002, 3'd2, 1, 22'h000000, 1, 1};
      vt[5]  = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h210001, 0, 1};
      vt[6]  = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h3A0002, 0, 0};
      vt[7]  = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h000000, 0, 0};
      vt[8]  = '{0, 1, 16'h00AA, 3'd3, 0, 1, 16'h0B01, 3'd4, 0, 22'h000000, 1, 1};
      vt[9]  = '{0, 1, 16'h00BB, 3'd3, 1, 1, 16'h0B02, 3'd4, 0, 22'h2300AA, 1, 2};
      vt[10] = '{0, 1, 16'h00CC, 3'd3, 0, 1, 16'h0B03, 3'd4, 0, 22'h340B01, 2, 1};
      vt[11] = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h2B00BB, 1, 1};
      vt[12] = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h340B02, 1, 0};
      vt[13] = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h2300CC, 0, 0};
      vt[14] = '{0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0, 22'h000000, 0, 0};

      reset = 1'b1;
      idle();
      add_data = '0; add_dest = '0; add_label = 1'b0;
      mul_data = '0; mul_dest = '0; mul_label = 1'b0;
      model_reset();
      #12;
      chk("in_reset.cdb", 32'(cdb), 32'h0);
      chk("in_reset.add_ready", 32'(add_ready), 32'h1);
      chk("in_reset.mul_ready", 32'(mul_ready), 32'h1);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step("idle_after_reset");

      // Directed vector table.
      for (int i = 0; i < 15; i++) begin
         flush = vt[i].fl;
         add_valid = vt[i].av; add_data = vt[i].ad; add_dest = vt[i].ade; add_label = vt[i].al;
         mul_valid = vt[i].mv; mul_data = vt[i].md; mul_dest = vt[i].mde; mul_label = vt[i].ml;
         step($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.cdb_tbl", i), 32'(cdb), 32'(vt[i].e_cdb));
         chk($sformatf("vec%0d.ac_tbl", i), 32'(add_count), 32'(vt[i].e_ac));
         chk($sformatf("vec%0d.mc_tbl", i), 32'(mul_count), 32'(vt[i].e_mc));
      end
      idle();

      // Sustained contention: both valid 6 cycles, data advances only on acceptance.
      flush = 1'b1;
      step("pre_contend_flush");
      flush = 1'b0;
      saw_add_stall = 1'b0; saw_mul_stall = 1'b0;
      a_seq = 0; m_seq = 0;
      for (int c = 0; c < 6; c++) begin
         add_valid = 1'b1; add_data = 16'hA000 + 16'(a_seq); add_dest = 3'd1; add_label = a_seq[0];
         mul_valid = 1'b1; mul_data = 16'hC000 + 16'(m_seq); mul_dest = 3'd6; mul_label = m_seq[0];
         if (add_ready) a_seq++;
         if (mul_ready) m_seq++;
         step("contend");
         if (!add_ready) saw_add_stall = 1'b1;
         if (!mul_ready) saw_mul_stall = 1'b1;
      end
      idle();
      for (int c = 0; c < 6; c++) step("contend_drain");
      chk("contend.add_stalled", 32'(saw_add_stall), 32'h1);
      chk("contend.mul_stalled", 32'(saw_mul_stall), 32'h1);

      // Asynchronous reset mid-cycle with both FIFOs occupied.
      for (int c = 0; c < 3; c++) begin
         add_valid = 1'b1; add_data = 16'h5500 + 16'(c); add_dest = 3'd2; add_label = 1'b0;
         mul_valid = 1'b1; mul_data = 16'h6600 + 16'(c); mul_dest = 3'd3; mul_label = 1'b1;
         step("pre_reset_fill");
      end
      idle();
      #3;
      reset = 1'b1;
      #1;
      chk("async_reset.cdb", 32'(cdb), 32'h0);
      chk("async_reset.add_count", 32'(add_count), 32'h0);
      chk("async_reset.mul_count", 32'(mul_count), 32'h0);
      chk("async_reset.add_ready", 32'(add_ready), 32'h1);
      chk("async_reset.mul_ready", 32'(mul_ready), 32'h1);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      step("post_reset");

      // Flush with both FIFOs occupied; the push in the flushing cycle is dropped.
      for (int c = 0; c < 3; c++) begin
         add_valid = 1'b1; add_data = 16'h7700 + 16'(c); add_dest = 3'd4; add_label = 1'b1;
         mul_valid = 1'b1; mul_data = 16'h8800 + 16'(c); mul_dest = 3'd5; mul_label = 1'b0;
         step("pre_flush_fill");
      end
      flush = 1'b1;
      add_valid = 1'b1; mul_valid = 1'b1;
      step("flush_edge");
      chk("flush.cdb", 32'(cdb), 32'h0);
      chk("flush.add_count", 32'(add_count), 32'h0);
      chk("flush.mul_count", 32'(mul_count), 32'h0);
      idle();
      step("post_flush");
      chk("post_flush.cdb", 32'(cdb), 32'h0);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         add_valid = 1'($urandom_range(0, 1));
         add_data  = 16'($urandom);
         add_dest  = 3'($urandom);
         add_label = 1'($urandom);
         mul_valid = 1'($urandom_range(0, 1));
         mul_data  = 16'($urandom);
         mul_dest  = 3'($urandom);
         mul_label = 1'($urandom);
         flush     = ($urandom_range(0, 31) == 0);
         step("random");
      end
      idle();
      for (int c = 0; c < 4; c++) step("random_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
